led_frame_driver: RTL and testbench

//  Parametrised LED column driver. Holds a double-buffered frame store of NUM_COLS columns x COL_WIDTH bits.
//  On command, it shifts the front buffer out on NUM_SHIFT parallel serial chains (SDO/SCLK), then pulses LAT.

---
 rtl/led_frame_driver.sv | 174 +++++++++++++++++
 tb/tb_led_frame_driver.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_driver.sv
// led_frame_driver: double-buffered LED column store. The front bank is shifted out
// on NUM_SHIFT parallel serial chains (SDO/SCLK), followed by a LAT pulse and a
// one-cycle done strobe. Column writes always land in the back bank.
module led_frame_driver #(
  parameter int NUM_SHIFT  = 4,
  parameter int NUM_COLS   = 128,
  parameter int COL_WIDTH  = 16,
  parameter int CLK_DIV    = 1,
  parameter int LAT_CYCLES = 2
) (
  input  logic                        spiClk,
  input  logic                        reset,
  input  logic                        wren,
  input  logic [$clog2(NUM_COLS)-1:0] wraddress,
  input  logic [COL_WIDTH-1:0]        ledCol,
  input  logic                        ledCmdStart,
  input  logic                        repeatEn,
  output logic                        ledCmdDone,
  output logic                        busy,
  output logic                        frontBank,
  output logic [NUM_SHIFT-1:0]        SDO,
  output logic                        SCLK,
  output logic                        LAT
);

  localparam int ADDR_W = $clog2(NUM_COLS);
  localparam int CPC    = NUM_COLS / NUM_SHIFT;
  localparam int CW     = (CPC > 1)        ? $clog2(CPC)        : 1;
  localparam int BW     = (COL_WIDTH > 1)  ? $clog2(COL_WIDTH)  : 1;
  localparam int DW     = (CLK_DIV > 1)    ? $clog2(CLK_DIV)    : 1;
  localparam int LW     = (LAT_CYCLES > 1) ? $clog2(LAT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_LATCH,
    S_DONE
  } state_t;

  logic [COL_WIDTH-1:0] mem [2][NUM_COLS];

  state_t               state;
  logic [DW-1:0]        div_cnt;
  logic [LW-1:0]        lat_cnt;
  logic [BW-1:0]        bit_idx;
  logic [CW-1:0]        col_idx;
  logic [BW-1:0]        nxt_bit;
  logic [CW-1:0]        nxt_col;
  logic [BW-1:0]        rd_bit;
  logic [CW-1:0]        rd_col;
  logic                 last_bit;
  logic [NUM_SHIFT-1:0] rd_sdo;
  logic                 addr_ok;

  // Out-of-range column addresses are dropped; with a power-of-two column count
  // every address is in range.
  generate
    if ((1 << ADDR_W) == NUM_COLS) begin : g_full_range
      assign addr_ok = 1'b1;
    end else begin : g_range_check
      assign addr_ok = (32'(wraddress) < NUM_COLS);
    end
  endgenerate

  // Column writes always target the bank that is not being displayed.
  always_ff @(posedge spiClk) begin
    if (wren && addr_ok) begin
      mem[~frontBank][wraddress] <= ledCol;
    end
  end

  // Next serial position and the bit each chain presents there. Bits are read
  // straight out of the store, so column boundaries never stall SCLK.
  always_comb begin
    last_bit = (bit_idx == '0) && (col_idx == '0);
    if (bit_idx == '0) begin
      nxt_bit = BW'(COL_WIDTH - 1);
      nxt_col = col_idx - CW'(1);
    end else begin
      nxt_bit = bit_idx - BW'(1);
      nxt_col = col_idx;
    end
    if (state == S_LOAD) begin
      rd_bit = BW'(COL_WIDTH - 1);
      rd_col = CW'(CPC - 1);
    end else begin
      rd_bit = nxt_bit;
      rd_col = nxt_col;
    end
    rd_sdo = '0;
    for (int unsigned k = 0; k < NUM_SHIFT; k++) begin
      rd_sdo[k] = mem[frontBank][ADDR_W'(k * CPC) + ADDR_W'(rd_col)][rd_bit];
    end
  end

  // Frame sequencer: bank swap on accept, serial shift, latch pulse, done strobe.
  always_ff @(posedge spiClk) begin
    if (reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      ledCmdDone <= 1'b0;
      frontBank  <= 1'b0;
      SDO        <= '0;
      SCLK       <= 1'b0;
      LAT        <= 1'b0;
      div_cnt    <= '0;
      lat_cnt    <= '0;
      bit_idx    <= '0;
      col_idx    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ledCmdStart) begin
            frontBank <= ~frontBank;
            busy      <= 1'b1;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          SDO     <= rd_sdo;
          SCLK    <= 1'b0;
          div_cnt <= '0;
          bit_idx <= BW'(COL_WIDTH - 1);
          col_idx <= CW'(CPC - 1);
          state   <= S_SHIFT;
        end
        S_SHIFT: begin
          if (div_cnt == DW'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            if (!SCLK) begin
              SCLK <= 1'b1;
            end else begin
              SCLK <= 1'b0;
              if (last_bit) begin
                SDO     <= '0;
                lat_cnt <= '0;
                state   <= S_LATCH;
              end else begin
                SDO     <= rd_sdo;
                bit_idx <= nxt_bit;
                col_idx <= nxt_col;
              end
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        S_LATCH: begin
          if (!LAT) begin
            LAT <= 1'b1;
          end else if (lat_cnt == LW'(LAT_CYCLES - 1)) begin
            LAT        <= 1'b0;
            ledCmdDone <= 1'b1;
            state      <= S_DONE;
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        S_DONE: begin
          ledCmdDone <= 1'b0;
          if (repeatEn) begin
            state <= S_LOAD;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_driver.sv
// Bench for led_frame_driver: stimulus pushes expected frames into a queue, a
// monitor reassembles the serial chains and checks each frame at its done pulse.
module tb_led_frame_driver;

  localparam int NUM_SHIFT = 4;
  localparam int NUM_COLS  = 128;
  localparam int COL_WIDTH = 16;
  localparam int CPC       = 32;
  localparam int NBITS     = 512;
  localparam int EXP_LAT   = 1029;   // 2 + 2*512*1 + 1 + 2
  localparam int EXP_LAT3  = 3077;   // 2 + 2*512*3 + 1 + 2
  localparam int FW        = NUM_COLS * COL_WIDTH;

  typedef struct packed {
    logic          front;
    logic          busy_after;
    logic [FW-1:0] data;
  } exp_t;

  logic spiClk = 1'b0;
  logic reset = 1'b1;
  logic wren = 1'b0;
  logic [6:0] wraddress = '0;
  logic [15:0] ledCol = '0;
  logic ledCmdStart = 1'b0;
  logic repeatEn = 1'b0;
  logic start3 = 1'b0;
  logic rep3 = 1'b0;

  logic ledCmdDone, busy, frontBank, SCLK, LAT;
  logic [NUM_SHIFT-1:0] SDO;
  logic done3, busy3, front3, sclk3, lat3;
  logic [NUM_SHIFT-1:0] sdo3;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  exp_t q[$];
  int q3[$];
  logic [FW-1:0] bank [2];
  logic front_model = 1'b0;
  exp_t e_s;

  led_frame_driver #(.NUM_SHIFT(4), .NUM_COLS(128), .COL_WIDTH(16), .CLK_DIV(1), .LAT_CYCLES(2)) dut (
    .spiClk(spiClk), .reset(reset), .wren(wren), .wraddress(wraddress), .ledCol(ledCol),
    .ledCmdStart(ledCmdStart), .repeatEn(repeatEn), .ledCmdDone(ledCmdDone), .busy(busy),
    .frontBank(frontBank), .SDO(SDO), .SCLK(SCLK), .LAT(LAT)
  );

  led_frame_driver #(.NUM_SHIFT(4), .NUM_COLS(128), .COL_WIDTH(16), .CLK_DIV(3), .LAT_CYCLES(2)) dut3 (
    .spiClk(spiClk), .reset(reset), .wren(wren), .wraddress(wraddress), .ledCol(ledCol),
    .ledCmdStart(start3), .repeatEn(rep3), .ledCmdDone(done3), .busy(busy3),
    .frontBank(front3), .SDO(sdo3), .SCLK(sclk3), .LAT(lat3)
  );

  always #5 spiClk = ~spiClk;
  always @(posedge spiClk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- main monitor ----------------
  logic prev_busy = 1'b0, prev_sclk = 1'b0, prev_done = 1'b0;
  logic [NUM_SHIFT-1:0] prev_sdo = '0;
  int ref_cyc = 0, rises = 0, lat_len = 0, viol = 0, sdo_age = 0, hi_len = 0;
  int mism = 0, first_bad = 0;
  logic [FW-1:0] cap = '0;
  logic chk_after = 1'b0, exp_busy_after = 1'b0;
  exp_t e;

  always @(negedge spiClk) begin
    if (reset) begin
      rises = 0; lat_len = 0; viol = 0; hi_len = 0; cap = '0; chk_after = 1'b0;
    end else begin
      if (chk_after) begin
        check("done_width", ledCmdDone, 0);
        check("busy_after_done", busy, exp_busy_after);
        chk_after = 1'b0;
      end
      if (busy && !prev_busy) begin
        ref_cyc = cyc - 1; rises = 0; lat_len = 0; viol = 0; cap = '0;
      end
      if (SDO != prev_sdo) sdo_age = 1; else sdo_age++;
      if (SCLK) hi_len++;
      else begin
        if (prev_sclk && hi_len != 1) viol++;
        hi_len = 0;
      end
      if (SCLK && !prev_sclk) begin
        if (sdo_age < 2) viol++;
        if (rises < NBITS) begin
          for (int k = 0; k < NUM_SHIFT; k++) begin
            cap[(k*CPC + CPC - 1 - rises/COL_WIDTH)*COL_WIDTH + COL_WIDTH - 1 - rises%COL_WIDTH] = SDO[k];
          end
        end
        rises++;
      end
      if (LAT) begin
        lat_len++;
        if (SDO != '0 || SCLK) viol++;
      end
      if (ledCmdDone && !prev_done) begin
        check("done_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("sclk_rises", rises, NBITS);
          check("lat_width", lat_len, 2);
          check("latency", cyc - ref_cyc, EXP_LAT);
          check("front_bank", frontBank, e.front);
          check("timing_violations", viol, 0);
          mism = 0; first_bad = -1;
          for (int c = 0; c < NUM_COLS; c++) begin
            if (cap[c*COL_WIDTH +: COL_WIDTH] !== e.data[c*COL_WIDTH +: COL_WIDTH]) begin
              mism++;
              if (first_bad < 0) first_bad = c;
            end
          end
          check("frame_data_cols", mism, 0);
          if (mism != 0)
            $display("  first differing column %0d: got %h want %h", first_bad,
                     cap[first_bad*COL_WIDTH +: COL_WIDTH], e.data[first_bad*COL_WIDTH +: COL_WIDTH]);
          exp_busy_after = e.busy_after;
          chk_after = 1'b1;
        end
        ref_cyc = cyc; rises = 0; lat_len = 0; viol = 0; cap = '0;
      end
    end
    prev_busy = busy; prev_sclk = SCLK; prev_done = ledCmdDone; prev_sdo = SDO;
  end

  // ---------------- CLK_DIV=3 monitor ----------------
  logic p3_busy = 1'b0, p3_sclk = 1'b0, p3_done = 1'b0;
  logic [NUM_SHIFT-1:0] p3_sdo = '0;
  int ref3 = 0, rises3 = 0, lat3_len = 0, viol3 = 0, age3 = 0, hi3 = 0, exp3 = 0;

  always @(negedge spiClk) begin
    if (reset) begin
      rises3 = 0; lat3_len = 0; viol3 = 0; hi3 = 0;
    end else begin
      if (busy3 && !p3_busy) begin
        ref3 = cyc - 1; rises3 = 0; lat3_len = 0; viol3 = 0;
      end
      if (sdo3 != p3_sdo) age3 = 1; else age3++;
      if (sclk3) hi3++;
      else begin
        if (p3_sclk && hi3 != 3) viol3++;
        hi3 = 0;
      end
      if (sclk3 && !p3_sclk) begin
        if (age3 < 4) viol3++;
        rises3++;
      end
      if (lat3) lat3_len++;
      if (done3 && !p3_done) begin
        check("d3_done_expected", q3.size() != 0, 1);
        if (q3.size() != 0) begin
          exp3 = q3.pop_front();
          check("d3_latency", cyc - ref3, exp3);
          check("d3_sclk_rises", rises3, NBITS);
          check("d3_lat_width", lat3_len, 2);
          check("d3_timing_violations", viol3, 0);
        end
      end
    end
    p3_busy = busy3; p3_sclk = sclk3; p3_done = done3; p3_sdo = sdo3;
  end

  // ---------------- stimulus ----------------
  task automatic write_col(input int addr, input logic [15:0] d);
    wren = 1'b1; wraddress = 7'(addr); ledCol = d;
    bank[~front_model][addr*COL_WIDTH +: COL_WIDTH] = d;
    @(negedge spiClk);
    wren = 1'b0;
  endtask

  task automatic start_frame(input int passes, input bit do_wr, input int addr, input logic [15:0] d);
    if (do_wr) begin
      wren = 1'b1; wraddress = 7'(addr); ledCol = d;
      bank[~front_model][addr*COL_WIDTH +: COL_WIDTH] = d;
    end
    ledCmdStart = 1'b1;
    front_model = ~front_model;
    for (int i = 0; i < passes; i++) begin
      e_s.front = front_model;
      e_s.busy_after = (i < passes - 1);
      e_s.data = bank[front_model];
      q.push_back(e_s);
    end
    @(negedge spiClk);
    ledCmdStart = 1'b0; wren = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while ((q.size() != 0 || busy) && n < max_cyc) begin
      @(negedge spiClk); n++;
    end
    check("idle_within_budget", (q.size() != 0 || busy), 0);
  endtask

  task automatic wait_q(input int target, input int max_cyc);
    int n = 0;
    while (q.size() > target && n < max_cyc) begin
      @(negedge spiClk); n++;
    end
    check("queue_drain_within_budget", q.size() > target, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, ledCmdDone, 0);
    check({tag, "_sdo"}, SDO, 0);
    check({tag, "_sclk"}, SCLK, 0);
    check({tag, "_lat"}, LAT, 0);
    check({tag, "_front"}, frontBank, 0);
  endtask

  initial begin
    int n;
    bank[0] = '0; bank[1] = '0;
    repeat (3) @(negedge spiClk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge spiClk);

    // 1: col c = c into bank 1, one frame
    for (int c = 0; c < NUM_COLS; c++) write_col(c, 16'(c));
    start_frame(1, 0, 0, 16'h0);
    wait_idle(2000);

    // 2: CLK_DIV=3 instance latency
    start3 = 1'b1;
    q3.push_back(EXP_LAT3);
    @(negedge spiClk);
    start3 = 1'b0;
    n = 0;
    while ((q3.size() != 0 || busy3) && n < 5000) begin
      @(negedge spiClk); n++;
    end
    check("d3_idle_within_budget", (q3.size() != 0 || busy3), 0);

    // 3: pattern into bank 0, start ignored while busy
    for (int c = 0; c < NUM_COLS; c++) write_col(c, 16'(c * 16'h0203) ^ 16'h5A5A);
    start_frame(1, 0, 0, 16'h0);
    repeat (200) @(negedge spiClk);
    ledCmdStart = 1'b1;
    @(negedge spiClk);
    ledCmdStart = 1'b0;
    @(negedge spiClk);
    check("front_after_ignored_start", frontBank, front_model);
    wait_idle(2000);

    // 4: back-bank writes during frame A, then all-ones frame with a same-cycle write
    start_frame(1, 0, 0, 16'h0);
    repeat (10) @(negedge spiClk);
    for (int c = 0; c < NUM_COLS; c++) write_col(c, 16'hFFFF);
    wait_idle(2000);
    start_frame(1, 1, 5, 16'h1234);
    wait_idle(2000);

    // 5: auto-repeat, three identical frames, then stop
    repeatEn = 1'b1;
    start_frame(3, 0, 0, 16'h0);
    repeat (50) @(negedge spiClk);
    write_col(0, 16'hBEEF);
    wait_q(1, 3000);
    repeat (300) @(negedge spiClk);
    repeatEn = 1'b0;
    wait_idle(2000);

    // 6: reset mid-frame, then replay bank 1
    start_frame(1, 0, 0, 16'h0);
    repeat (402) @(negedge spiClk);
    reset = 1'b1;
    @(negedge spiClk);
    check_reset_outputs("midreset");
    q.delete();
    front_model = 1'b0;
    repeat (2) @(negedge spiClk);
    reset = 1'b0;
    repeat (20) @(negedge spiClk);
    start_frame(1, 0, 0, 16'h0);
    wait_idle(2000);

    repeat (5) @(negedge spiClk);
    check("frames_pending", q.size(), 0);
    check("d3_frames_pending", q3.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
